// File: rtl/shift_feeder.sv
// shift_feeder: serializes parallel words into a bit stream for a downstream
// shift register, one bit per clock, with an optional idle gap after each word.
//
// Parameters
//   WIDTH  bits per word (2..16)
//   GAP    idle cycles inserted after each word (0..15)
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_data   parallel word, captured on an in_valid/in_ready handshake
//   in_dir    direction tag: 0 = MSB first, 1 = LSB first
//   in_valid  upstream word available
//   in_ready  block can accept a word this cycle (never depends on in_valid)
//   d         serial bit to the downstream register (registered)
//   dir       direction to the downstream register (registered, held)
//   busy      high while shifting or in the gap (registered)
//   done      pulses in the cycle the last bit of a word is on d (registered)
module shift_feeder #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);
  localparam logic [3:0] LAST_GAP = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             d_q, d_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] word_oriented;

  // Words are stored so that the next bit to send is always the MSB;
  // an LSB-first word is therefore bit-reversed once at capture time.
  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] w,
                                              input logic             lsb_first);
    logic [WIDTH-1:0] r;
    r = w;
    if (lsb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        r[i] = w[WIDTH-1-i];
      end
    end
    return r;
  endfunction

  // Ready in IDLE, or in the final bit cycle when no gap follows so that
  // back-to-back words stream without a bubble. Forced low during reset.
  assign in_ready = rst_n &&
                    ((state_q == ST_IDLE) ||
                     ((GAP == 0) && (state_q == ST_SHIFT) && (cnt_q == LAST_BIT)));

  assign accept        = in_valid && in_ready;
  assign word_oriented = orient(in_data, in_dir);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    d_d     = 1'b0;
    dir_d   = dir_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_q != LAST_BIT) begin
          cnt_d   = cnt_q + 4'd1;
          d_d     = shift_q[WIDTH-1];
          shift_d = shift_q << 1;
          busy_d  = 1'b1;
          done_d  = ((cnt_q + 4'd1) == LAST_BIT);
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      ST_GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // A handshake overrides whatever the current state decided: the first
    // bit goes straight to d so it appears one cycle after the edge.
    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = 4'd0;
      d_d     = word_oriented[WIDTH-1];
      shift_d = word_oriented << 1;
      dir_d   = in_dir;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      shift_q <= '0;
      d_q     <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      d_q     <= d_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d    = d_q;
  assign dir  = dir_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/shift_feeder.md
SHIFT_FEEDER -- requirements
Module: shift_feeder

Interface
REQ-001 Parameter WIDTH, default 4, bits per word; legal range 2..16.
REQ-002 Parameter GAP, default 0, idle cycles inserted after each word; legal range 0..15.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_dir  input  1  direction tag for the word, forwarded to the downstream shift register.
REQ-007 in_valid  input  1  upstream word available.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 d  output  1  serial bit driven to the downstream register's d input.
REQ-010 dir  output  1  direction driven to the downstream register's dir input.
REQ-011 busy  output  1  high while in SHIFT or GAP.
REQ-012 done  output  1  one-cycle pulse marking the cycle in which the last bit of a word is driven.

Function
REQ-013 The block SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, capturing in_data and in_dir into internal registers.
REQ-014 in_data and in_dir SHALL be ignored in any cycle without a handshake.
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-016 IDLE: in_ready=1, d=0, busy=0; on handshake -> SHIFT.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, with a bit counter running 0..WIDTH-1, and drive one bit per cycle on d.
REQ-018 The first bit SHALL appear on d in the cycle immediately after the handshake edge (latency 1).
REQ-019 Bit order SHALL be MSB first when the captured dir=0 and LSB first when the captured dir=1.
REQ-020 dir SHALL equal the captured in_dir for the whole of SHIFT, and SHALL hold that value through GAP and IDLE until the next handshake.
REQ-021 done SHALL be 1 exactly in the cycle the bit at counter=WIDTH-1 is driven, and 0 otherwise.
REQ-022 In the last SHIFT cycle with GAP=0, in_ready SHALL be 1.
  - Handshake that cycle -> SHIFT restarts at counter 0, giving a contiguous bit stream with no bubble.
  - No handshake that cycle -> IDLE.
REQ-023 In the last SHIFT cycle with GAP>0, in_ready SHALL be 0; next state -> GAP.
REQ-024 GAP SHALL last exactly GAP cycles, with in_ready=0, d=0 and busy=1, then -> IDLE.
REQ-025 in_ready SHALL be 0 in all SHIFT cycles other than the case covered by REQ-022.
REQ-026 in_ready SHALL be a combinational function of state, counter and GAP only, with no path from in_valid.
REQ-027 d, dir, busy and done SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-028 While rst_n=0 at a rising edge, the block SHALL enter IDLE with counter=0, captured word=0, d=0, dir=0, busy=0 and done=0.
REQ-029 in_ready SHALL be 0 in every cycle in which rst_n=0.
REQ-030 A reset asserted mid-word or mid-gap SHALL discard the word, with outputs at reset values from the next cycle onward.
REQ-031 After rst_n returns to 1, the block SHALL accept a handshake in the first cycle.

Verification
REQ-032 Reset: hold rst_n=0 for 2 cycles with in_valid=1 and in_data=4'hF.
  -> in_ready=0 throughout, no capture.
  -> after release: d=0, dir=0, busy=0, done=0, in_ready=1.
REQ-033 WIDTH=4, GAP=0: handshake in_data=4'b1011, in_dir=0.
  -> d = 1,0,1,1 on cycles 1..4 after the edge.
  -> busy=1 on cycles 1..4; done=1 on cycle 4 only; IDLE on cycle 5.
REQ-034 Handshake in_data=4'b1011, in_dir=1.
  -> d = 1,1,0,1.
  -> dir=1 during SHIFT, and still 1 in IDLE afterwards.
REQ-035 GAP=0, in_valid held 1, words 4'b1100 then 4'b0011, both in_dir=0.
  -> eight contiguous d bits 1,1,0,0,0,0,1,1.
  -> in_ready=1 on cycle 4; done on cycles 4 and 8.
REQ-036 GAP=2, in_valid held 1.
  -> in_ready=0 for 6 cycles after the handshake; d=0 and busy=1 in the 2 gap cycles.
  -> next word's first bit appears on cycle 8.
REQ-037 Reset mid-word: rst_n=0 during bit 2 of 4'b1111.
  -> next cycle d=0, busy=0, done=0, dir=0.
  -> no done pulse for the aborted word.
